accum_feeder: RTL and testbench



---
 rtl/accum_feeder.sv | 88 ++++++++
 tb/tb_accum_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/accum_feeder.sv
// Small valid/ready FIFO that feeds one registered increment strobe per cycle into the accumulator.
// Optional ACCUM_FEEDER_MIRROR_EN adds a mirror_sum register tracking the downstream running sum.
module accum_feeder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       pause,
  input  logic                       clr_err,
  output logic                       tock_valid,
  output logic [WIDTH-1:0]           tock_arg,
  output logic [$clog2(DEPTH):0]     count,
`ifdef ACCUM_FEEDER_MIRROR_EN
  output logic                       overflow_err,
  output logic [WIDTH-1:0]           mirror_sum
`else
  output logic                       overflow_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Full/empty come from count alone, so pointers may simply wrap.
  assign in_ready = rst_n && (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !pause;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tock_valid   <= 1'b0;
      tock_arg     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        tock_arg   <= mem[rd_ptr];
        tock_valid <= 1'b1;
        rd_ptr     <= rd_ptr + AW'(1);
      end else begin
        tock_valid <= 1'b0;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      // A new offence in the same cycle as a clear keeps the flag set.
      if (in_valid && !in_ready) begin
        overflow_err <= 1'b1;
      end else if (clr_err) begin
        overflow_err <= 1'b0;
      end
    end
  end

`ifdef ACCUM_FEEDER_MIRROR_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      mirror_sum <= '0;
    end else if (tock_valid) begin
      mirror_sum <= mirror_sum + tock_arg;
    end
  end
`endif

endmodule

// File: tb/tb_accum_feeder.sv
// Scoreboard bench for accum_feeder: expected strobe values are queued at issue time
// and a separate monitor pops and compares them whenever tock_valid is seen.
module tb_accum_feeder;

  logic       clock;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       pause;
  logic       clr_err;
  logic       tock_valid;
  logic [7:0] tock_arg;
  logic [2:0] count;
  logic       overflow_err;
`ifdef ACCUM_FEEDER_MIRROR_EN
  logic [7:0] mirror_sum;
`endif

  int checks;
  int failures;
  logic [7:0] expQ[$];

  accum_feeder #(.DEPTH(4), .WIDTH(8)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .pause(pause),
    .clr_err(clr_err),
    .tock_valid(tock_valid),
    .tock_arg(tock_arg),
    .count(count),
`ifdef ACCUM_FEEDER_MIRROR_EN
    .overflow_err(overflow_err),
    .mirror_sum(mirror_sum)
`else
    .overflow_err(overflow_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic p, input logic c, input logic accept);
    in_valid = v;
    in_data  = d;
    pause    = p;
    clr_err  = c;
    if (accept) expQ.push_back(d);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Monitor: every observed strobe must match the oldest expected value.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clock);
      if (tock_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL sb_unexpected: got strobe arg %0d expected no strobe at %0t", tock_arg, $time);
        end else begin
          exp = expQ.pop_front();
          checkOutput("sb_tock_arg", {24'd0, tock_arg}, {24'd0, exp});
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    #12;
    checkOutput("reset_count", {29'd0, count}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("reset_tock_valid", {31'd0, tock_valid}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow_err}, 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    checkOutput("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Single push of 72
    applyStimulus(1'b1, 8'd72, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("single_count1", {29'd0, count}, 32'd1);
    checkOutput("single_no_bypass", {31'd0, tock_valid}, 32'd0);
    tick();
    checkOutput("single_count0", {29'd0, count}, 32'd0);
    checkOutput("single_strobe", {31'd0, tock_valid}, 32'd1);
    tick();
    checkOutput("single_strobe_end", {31'd0, tock_valid}, 32'd0);

    // Fill while paused, then overflow behaviour
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
      tick();
    end
    checkOutput("fill_count", {29'd0, count}, 32'd4);
    checkOutput("fill_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("fill_no_strobe", {31'd0, tock_valid}, 32'd0);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_set", {31'd0, overflow_err}, 32'd1);
    checkOutput("ovf_count", {29'd0, count}, 32'd4);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_sticky", {31'd0, overflow_err}, 32'd1);
    applyStimulus(1'b1, 8'd6, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_set_wins", {31'd0, overflow_err}, 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_cleared", {31'd0, overflow_err}, 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("drain_strobe", {31'd0, tock_valid}, 32'd1);
      checkOutput("drain_count", {29'd0, count}, 32'(4 - i));
    end
    tick();
    checkOutput("drain_done", {31'd0, tock_valid}, 32'd0);

    // Full plus pop: offered data is refused that cycle
    for (int i = 10; i <= 13; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b1, 8'd99, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("fullpop_count", {29'd0, count}, 32'd3);
    checkOutput("fullpop_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("fullpop_ovf", {31'd0, overflow_err}, 32'd1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("fullpop_drained", {29'd0, count}, 32'd0);
    checkOutput("fullpop_ovf_clr", {31'd0, overflow_err}, 32'd0);

    // Concurrent push/pop at count=2 across pointer wrap
    applyStimulus(1'b1, 8'd20, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'd21, 1'b1, 1'b0, 1'b1);
    tick();
    for (int i = 22; i < 30; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("steady_count", {29'd0, count}, 32'd2);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("steady_drained", {29'd0, count}, 32'd0);

    // Asynchronous reset mid-drain
    for (int i = 7; i <= 10; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("middrain_count", {29'd0, count}, 32'd3);
    #2;
    expQ.delete();
    rst_n = 1'b0;
    #1;
    checkOutput("async_tock_valid", {31'd0, tock_valid}, 32'd0);
    checkOutput("async_count", {29'd0, count}, 32'd0);
    checkOutput("async_overflow", {31'd0, overflow_err}, 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 8'd36, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("post_reset_strobe", {31'd0, tock_valid}, 32'd1);
    tick();
    checkOutput("post_reset_idle", {31'd0, tock_valid}, 32'd0);

`ifdef ACCUM_FEEDER_MIRROR_EN
    // Mirror from a clean reset: 200 then 200+100 mod 256
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    checkOutput("mirror_reset", {24'd0, mirror_sum}, 32'd0);
    applyStimulus(1'b1, 8'd200, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 8'd100, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("mirror_first", {24'd0, mirror_sum}, 32'd200);
    tick();
    checkOutput("mirror_wrap", {24'd0, mirror_sum}, 32'd44);
`endif

    begin
      int budget;
      budget = 0;
      while (expQ.size() != 0 && budget < 20) begin
        tick();
        budget++;
      end
      checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no completion expected finish before %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
